// File: rtl/scope_capture.sv
// Triggered sample-capture buffer: circular DEPTH-sample record with pre-trigger
// length and level/slope trigger, read over the system bus. Option: SCOPE_DECIM_EN.
module scope_capture #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk24,
  input  logic          resetn,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          sel,
  input  logic [3:0]    we,
  input  logic [15:0]   addr,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat,
  output logic          rdy,
  output logic          done
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_V   = {{AW{1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [DW-1:0] r_mem [DEPTH];
  logic [2:0]    r_state;
  logic [DW-1:0] r_level;
  logic [AW-1:0] r_pre;
  logic          r_slope;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_tptr;
  logic [AW:0]   r_cnt;
  logic [DW-1:0] r_prev;
  logic          r_prev_ok;
  logic          r_force;

  logic          w_acc;
  logic          w_first, w_wr, w_ctrl_wr;
  logic          w_arm, w_force, w_abort;
  logic          w_capt;
  logic [AW:0]   w_cnt_inc;
  logic [AW:0]   w_post_len;
  logic          w_trig_lvl, w_trig;
  logic [AW-1:0] w_start;
  logic [31:0]   w_rd;
  logic          w_unused;

`ifdef SCOPE_DECIM_EN
  logic [7:0]    r_decim;
  logic [7:0]    r_dcnt;
  assign w_acc = din_valid & (r_dcnt == 8'd0);
`else
  assign w_acc = din_valid;
`endif

  assign w_first    = sel & ~rdy;
  assign w_wr       = w_first & (|we) & ~addr[15];
  assign w_ctrl_wr  = w_wr & (addr[4:2] == 3'd0);
  assign w_arm      = w_ctrl_wr & wdat[0];
  assign w_force    = w_ctrl_wr & wdat[1];
  assign w_abort    = w_ctrl_wr & wdat[3];
  assign w_capt     = w_acc & ((r_state == S_PRE) | (r_state == S_WAIT) | (r_state == S_POST));
  assign w_cnt_inc  = r_cnt + ONE_V;
  assign w_post_len = DEPTH_V - {1'b0, r_pre};
  assign w_trig_lvl = r_slope ? ((r_prev >= r_level) && (din < r_level))
                              : ((r_prev < r_level) && (din >= r_level));
  assign w_trig     = r_force | (r_prev_ok & w_trig_lvl);
  assign w_start    = r_tptr - r_pre;
  assign w_unused   = &{1'b0, addr, wdat, we};

  always_ff @(posedge clk24) begin
    if (w_capt) r_mem[r_wptr] <= din;
  end

  always_comb begin
    w_rd = '0;
    if (addr[15]) begin
      w_rd[DW-1:0] = r_mem[addr[AW+1:2]];
    end else begin
      case (addr[4:2])
        3'd1: w_rd[DW-1:0] = r_level;
        3'd2: w_rd[AW-1:0] = r_pre;
        3'd3: w_rd = {23'b0, done, 5'b0, r_state};
        3'd4: w_rd[AW-1:0] = w_start;
`ifdef SCOPE_DECIM_EN
        3'd5: w_rd[7:0] = r_decim;
`endif
        default: w_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk24 or negedge resetn) begin
    if (!resetn) begin
      rdat <= '0;
      rdy  <= 1'b0;
    end else begin
      rdy <= sel & ~rdy;
      if (w_first) rdat <= w_rd;
    end
  end

  always_ff @(posedge clk24 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_level   <= '0;
      r_pre     <= '0;
      r_slope   <= 1'b0;
      r_wptr    <= '0;
      r_tptr    <= '0;
      r_cnt     <= '0;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
      r_force   <= 1'b0;
      done      <= 1'b0;
`ifdef SCOPE_DECIM_EN
      r_decim   <= '0;
      r_dcnt    <= '0;
`endif
    end else begin
      if (w_wr) begin
        case (addr[4:2])
          3'd0: r_slope <= wdat[2];
          3'd1: r_level <= wdat[DW-1:0];
          3'd2: r_pre   <= wdat[AW-1:0];
`ifdef SCOPE_DECIM_EN
          3'd5: r_decim <= wdat[7:0];
`endif
          default: ;
        endcase
      end
`ifdef SCOPE_DECIM_EN
      if (din_valid) r_dcnt <= (r_dcnt >= r_decim) ? 8'd0 : r_dcnt + 8'd1;
`endif
      // sample path sees pre-write register values; commands below override it
      if (w_capt) begin
        r_wptr <= r_wptr + 1'b1;
        r_prev <= din;
        case (r_state)
          S_PRE: begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == {1'b0, r_pre}) r_state <= S_WAIT;
          end
          S_WAIT: begin
            r_prev_ok <= 1'b1;
            if (w_trig) begin
              r_tptr  <= r_wptr;
              r_cnt   <= ONE_V;
              r_force <= 1'b0;
              if (w_post_len == ONE_V) begin
                r_state <= S_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= S_POST;
              end
            end
          end
          S_POST: begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_post_len) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (w_force && ((r_state == S_PRE) || (r_state == S_WAIT))) r_force <= 1'b1;
      if (w_abort) begin
        r_state <= S_IDLE;
        done    <= 1'b0;
      end
      if (w_arm) begin
        r_wptr    <= '0;
        r_cnt     <= '0;
        r_prev_ok <= 1'b0;
        r_force   <= 1'b0;
        done      <= 1'b0;
        r_state   <= (r_pre == '0) ? S_WAIT : S_PRE;
`ifdef SCOPE_DECIM_EN
        r_dcnt    <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_scope_capture.sv
// Scoreboard bench for scope_capture: bus reads queue expected data, a monitor
// compares whenever rdy is presented.
module tb_scope_capture;

  logic        clk24 = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        sel = 1'b0;
  logic [3:0]  we = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        rdy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  bit          q_chk [$];
  logic [31:0] q_exp [$];
  string       q_nm  [$];

  scope_capture #(.DW(12), .AW(9)) dut (
    .clk24(clk24), .resetn(resetn), .din(din), .din_valid(din_valid),
    .sel(sel), .we(we), .addr(addr), .wdat(wdat),
    .rdat(rdat), .rdy(rdy), .done(done)
  );

  always #5 clk24 = ~clk24;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk24) begin
    if (rdy) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rdy: got rdy=1 required no bus cycle");
      end else begin
        bit          c;
        logic [31:0] e;
        string       nm;
        c  = q_chk.pop_front();
        e  = q_exp.pop_front();
        nm = q_nm.pop_front();
        if (c) begin
          n_tests++;
          if (rdat !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, rdat, e);
          end
        end
      end
    end
  end

  task automatic bus_cycle(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
    @(posedge clk24); #1;
    sel = 1'b1; addr = a; we = w; wdat = d;
    @(posedge clk24); #1;
    sel = 1'b0; we = '0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    q_chk.push_back(1'b1); q_exp.push_back(e); q_nm.push_back(nm);
    bus_cycle(a, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    q_chk.push_back(1'b0); q_exp.push_back(32'h0); q_nm.push_back("wr");
    bus_cycle(a, 4'hF, d);
  endtask

  function automatic logic [15:0] baddr(input int i);
    logic [31:0] t;
    t = 32'h8000 | (i << 2);
    return t[15:0];
  endfunction

  task automatic ramp(input int from, input int to);
    for (int v = from; v <= to; v++) begin
      logic [31:0] t;
      t = v;
      @(posedge clk24); #1;
      din = t[11:0]; din_valid = 1'b1;
      @(posedge clk24); #1;
      din_valid = 1'b0;
    end
  endtask

  // LEVEL=100, PRE=16, rising, already armed with wptr=0
  task automatic scn2(input string tag);
    rd(16'h000C, 32'h1, {tag, "_st_pre"});
    ramp(0, 15);
    rd(16'h000C, 32'h2, {tag, "_st_wait"});
    ramp(16, 99);
    rd(16'h000C, 32'h2, {tag, "_st_wait99"});
    ramp(100, 100);
    rd(16'h000C, 32'h3, {tag, "_st_post"});
    rd(16'h0010, 32'd84, {tag, "_start"});
    ramp(101, 594);
    chk({tag, "_done_early"}, {31'b0, done}, 32'h0);
    ramp(595, 595);
    chk({tag, "_done"}, {31'b0, done}, 32'h1);
    rd(16'h000C, 32'h104, {tag, "_st_done"});
    ramp(999, 999);
    rd(baddr(84), 32'd84, {tag, "_buf_start"});
    rd(baddr(100), 32'd100, {tag, "_buf_trig"});
    rd(baddr(83), 32'd595, {tag, "_buf_last"});
  endtask

  initial begin
    repeat (3) @(posedge clk24);
    #1;
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_rdat", rdat, 32'h0);
    chk("rst_rdy", {31'b0, rdy}, 32'h0);
    resetn = 1'b1;
    rd(16'h000C, 32'h0, "rst_status");
    @(posedge clk24); #1;
    chk("rdy_one_cycle", {31'b0, rdy}, 32'h0);
    wr(16'h0018, 32'hFFFF_FFFF);
    rd(16'h0018, 32'h0, "unmapped_rd");

    wr(16'h0004, 32'd100);
    wr(16'h0008, 32'd16);
    rd(16'h0004, 32'd100, "level_rd");
    rd(16'h0008, 32'd16, "pre_rd");
    wr(16'h0000, 32'h1);
    rd(16'h0000, 32'h0, "ctrl_rd0");
    scn2("s2");

    // falling slope on rising ramp, then forced trigger
    wr(16'h0000, 32'h5);
    ramp(0, 1999);
    rd(16'h000C, 32'h2, "fall_no_trig");
    wr(16'h0000, 32'h6);
    rd(16'h000C, 32'h2, "force_wait");
    ramp(2000, 2000);
    rd(16'h000C, 32'h3, "force_post");
    rd(16'h0010, 32'd448, "force_start");
    rd(baddr(464), 32'd2000, "force_buf");
    ramp(2001, 2494);
    chk("force_done_early", {31'b0, done}, 32'h0);
    ramp(2495, 2495);
    chk("force_done", {31'b0, done}, 32'h1);

    // PRE=0 goes straight to WAIT
    wr(16'h0008, 32'd0);
    wr(16'h0004, 32'd10);
    wr(16'h0000, 32'h1);
    rd(16'h000C, 32'h2, "p0_wait");
    ramp(0, 9);
    rd(16'h000C, 32'h2, "p0_wait9");
    ramp(10, 10);
    rd(16'h000C, 32'h3, "p0_post");
    rd(16'h0010, 32'd10, "p0_start");
    ramp(11, 520);
    chk("p0_done_early", {31'b0, done}, 32'h0);
    ramp(521, 521);
    chk("p0_done", {31'b0, done}, 32'h1);
    rd(baddr(10), 32'd10, "p0_buf");

    // abort mid-POST, then ARM+ABORT in one write re-arms
    wr(16'h0004, 32'd100);
    wr(16'h0008, 32'd16);
    wr(16'h0000, 32'h1);
    ramp(0, 200);
    rd(16'h000C, 32'h3, "ab_post");
    wr(16'h0000, 32'h8);
    rd(16'h000C, 32'h0, "ab_idle");
    chk("ab_done", {31'b0, done}, 32'h0);
    ramp(3000, 3000);
    rd(baddr(201), 32'd201, "ab_nowrite");
    wr(16'h0000, 32'h9);
    scn2("rearm");

    // async reset mid-POST
    wr(16'h0000, 32'h1);
    ramp(0, 150);
    rd(16'h000C, 32'h3, "rr_post");
    @(posedge clk24); #1;
    resetn = 1'b0;
    #3;
    chk("rr_done", {31'b0, done}, 32'h0);
    chk("rr_rdat", rdat, 32'h0);
    @(posedge clk24); #1;
    resetn = 1'b1;
    rd(16'h000C, 32'h0, "rr_status");
    rd(16'h0004, 32'h0, "rr_level");
    rd(16'h0008, 32'h0, "rr_pre");

`ifdef SCOPE_DECIM_EN
    wr(16'h0014, 32'd3);
    rd(16'h0014, 32'd3, "dec_rd");
    wr(16'h0004, 32'd100);
    wr(16'h0008, 32'd16);
    wr(16'h0000, 32'h1);
    ramp(0, 104);
    rd(16'h000C, 32'h3, "dec_post");
    rd(16'h0010, 32'd9, "dec_start");
    rd(baddr(9), 32'd36, "dec_buf0");
    rd(baddr(10), 32'd40, "dec_buf1");
`else
    rd(16'h0014, 32'h0, "dec_absent");
`endif

    repeat (4) @(posedge clk24);
    if (q_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending required 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Triggered sample-capture buffer for up5k_osc, upstream of the picorv32 system; it turns the ADC sample stream into a CPU-readable record.
- Stores a DEPTH-sample circular record with programmable pre-trigger length and a level/slope trigger.
- Attaches to the system bus at slot 4'h4, using the same sel/wstrb/1-cycle-ready protocol as the other peripherals.

Parameters:
- DW, 12, sample width in bits.
- AW, 9, buffer address width; DEPTH = 2**AW samples.

Ports:
- clk24  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- din  in  DW  sample from ADC front-end.
- din_valid  in  1  one-cycle strobe qualifying din.
- sel  in  1  bus select (address decode & mem_valid).
- we  in  4  byte write strobes.
- addr  in  16  byte address.
- wdat  in  32  write data.
- rdat  out  32  registered read data.
- rdy  out  1  bus ready.
- done  out  1  capture complete, level.

Behaviour:
- Reset, async on resetn low: state IDLE; rdat=0, rdy=0, done=0; LEVEL=0, PRE=0, SLOPE=0; wptr=0; all counters 0.
- Bus timing: rdy <= sel & ~rdy, so ready is high exactly one cycle after sel, then low. rdat loads on the same edge from the decoded location. Writes take effect on the first sel cycle when any we bit is set.
- Decode, addr[15]=0, registers selected by addr[4:2]:
  - 0x00 CTRL, write-only, reads 0:
    - b0 ARM: 1 = start capture.
    - b1 FORCE: 1 = force trigger.
    - b2 SLOPE: 0 rising, 1 falling; stored bit.
    - b3 ABORT.
  - 0x04 LEVEL[DW-1:0].
  - 0x08 PRE[AW-1:0]. Writes above DEPTH-1 are impossible by width.
  - 0x0C STATUS, read-only:
    - [2:0] state: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.
    - b8 done.
  - 0x10 START, read-only: (tptr - PRE) mod DEPTH.
  - Other register offsets read 0; writes to them are ignored.
- Buffer window, addr[15]=1:
  - Reads return buffer[addr[AW+1:2]], zero-extended.
  - Writes are ignored.
- Sample write port: each din_valid in PRE/WAIT/POST writes buffer[wptr] <= din, then wptr <= wptr+1 mod DEPTH (wraps silently).
- State machine, advanced only on din_valid unless stated otherwise:
  - ARM (any state): wptr=0, cnt=0, prev_ok=0, done=0, force pending cleared. Next state is PRE, or WAIT directly if PRE=0.
  - PRE: cnt increments per sample. When cnt reaches PRE, go to WAIT.
  - WAIT:
    - Trigger on the current sample when:
      - rising: prev<LEVEL && din>=LEVEL;
      - falling: prev>=LEVEL && din<LEVEL;
      - or a force is pending.
    - prev is the previous accepted sample. prev_ok is 0 for the first WAIT sample, so that sample cannot trigger on level.
    - On trigger: tptr=wptr of the trigger sample, cnt=1, go to POST.
  - POST: the trigger sample counts as post sample 1. When cnt reaches DEPTH-PRE, go to DONE and set done=1.
  - DONE: no buffer writes; hold until ARM.
- FORCE:
  - In PRE: sets a pending flag that is honoured on the first WAIT sample.
  - In WAIT: triggers on the next sample.
  - In other states: ignored.
- ABORT, any state: go to IDLE with done=0. If ARM and ABORT are set in the same write, ARM wins.
- A sample landing in the same cycle as a register write is processed with the old register values.
- CPU reads of the buffer during capture return current RAM contents. No stall.
- Unsigned compare for the trigger; LEVEL applies at full DW width.

Optional Feature:
- SCOPE_DECIM_EN defined:
  - Adds register 0x14 DECIM[7:0], reset 0.
  - Only every (DECIM+1)-th din_valid is accepted; the others are dropped before the buffer and before trigger logic.
  - The decimation counter is cleared by ARM.
- Undefined: 0x14 reads 0 and every din_valid is accepted.

Test Plan:
- Reset check: after resetn low, STATUS=0, done=0, rdat=0. A single-cycle sel read asserts rdy for exactly 1 cycle, 1 clock later.
- Ramp din=0,1,2,... with LEVEL=100, PRE=16, rising, then ARM:
  - trigger on value 100; START=84; done after 496 post samples;
  - buffer[START]=84, buffer[START+16]=100, buffer[(START+511)%512]=595.
- Falling slope on a rising ramp never triggers (STATUS=2 for 2000 samples). FORCE while in WAIT triggers on the next sample, value v; that sample sits at START+PRE and done follows DEPTH-PRE samples later.
- PRE=0, LEVEL=10, ramp from 0: state goes IDLE->WAIT; buffer[START]=10; done after 512 samples.
- ABORT mid-POST returns STATUS=0, done=0, with no further writes. Re-ARM repeats scenario 2 results.
- resetn pulsed low mid-POST: STATUS reads 0 immediately after release and LEVEL/PRE read 0. With SCOPE_DECIM_EN and DECIM=3, the scenario 2 ramp gives buffer[START+1]-buffer[START]=4.
